hazard_fwd_unit: RTL

- Control end of the ID/EX pipeline register interface: consumes the rs/rt/rd fields that ID/EX presents to EX and drives the enableID/resetID (and IF/ID, PC) control pins that hold or bubble it.
- Provides load-use stall, branch flush, a data-memory busy freeze with timeout, EX operand forwarding selects, and saturating stall/flush counters.
- Sits beside the decode/execute stages of the 5-stage pipeline.

---
 rtl/mips_pipe_pkg.sv | 17 +
 rtl/fwd_sel.sv | 23 ++
 rtl/hazard_fwd_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared encodings for the 5-stage pipeline control logic: forwarding selects,
// hazard unit states and the hard-wired zero register.
package mips_pipe_pkg;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StWaitMem = 2'b01,
    StErr     = 2'b10
  } hz_state_e;

endpackage

// File: rtl/fwd_sel.sv
// EX operand source selector: picks the youngest in-flight producer of src_i,
// never forwarding register 0.
module fwd_sel
  import mips_pipe_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic [4:0] ex_mem_dst_i,
  input  logic       ex_mem_regwrite_i,
  input  logic [4:0] mem_wb_dst_i,
  input  logic       mem_wb_regwrite_i,
  output logic [1:0] sel_o
);

  always_comb begin
    sel_o = FWD_REG;
    if (ex_mem_regwrite_i && (ex_mem_dst_i != REG_ZERO) && (ex_mem_dst_i == src_i)) begin
      sel_o = FWD_EXMEM;
    end else if (mem_wb_regwrite_i && (mem_wb_dst_i != REG_ZERO) && (mem_wb_dst_i == src_i)) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard control: load-use stall, branch flush, data-memory freeze with
// timeout, EX forwarding selects and saturating stall/flush counters.
module hazard_fwd_unit
  import mips_pipe_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             reloj,
  input  logic             reset_n,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             if_id_use_rt,
  input  logic [4:0]       id_ex_rs,
  input  logic [4:0]       id_ex_rt,
  input  logic [4:0]       id_ex_dst,
  input  logic             id_ex_memread,
  input  logic [4:0]       ex_mem_dst,
  input  logic             ex_mem_regwrite,
  input  logic [4:0]       mem_wb_dst,
  input  logic             mem_wb_regwrite,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  output logic             pc_en,
  output logic             enableIF,
  output logic             resetIF,
  output logic             enableID,
  output logic             resetID,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WaitW = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);

  hz_state_e        state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;

  logic load_use, stall_inc, flush_inc;
  logic pc_en_c, en_if_c, rst_if_c, en_id_c, rst_id_c;
  logic [1:0] sel_a, sel_b;

  assign load_use = id_ex_memread && (id_ex_dst != REG_ZERO) &&
                    ((id_ex_dst == if_id_rs) || (if_id_use_rt && (id_ex_dst == if_id_rt)));

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_err_d = mem_err_q;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    pc_en_c   = 1'b0;
    en_if_c   = 1'b0;
    rst_if_c  = 1'b0;
    en_id_c   = 1'b0;
    rst_id_c  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (dmem_busy) begin
          state_d   = StWaitMem;
          wait_d    = '0;
          stall_inc = 1'b1;
        end else if (branch_taken) begin
          // Flush wins over load-use: the stalled instruction is squashed anyway.
          pc_en_c   = 1'b1;
          en_if_c   = 1'b1;
          rst_if_c  = 1'b1;
          en_id_c   = 1'b1;
          rst_id_c  = 1'b1;
          flush_inc = 1'b1;
        end else if (load_use) begin
          en_id_c   = 1'b1;
          rst_id_c  = 1'b1;
          stall_inc = 1'b1;
        end else begin
          pc_en_c = 1'b1;
          en_if_c = 1'b1;
          en_id_c = 1'b1;
        end
      end
      StWaitMem: begin
        stall_inc = 1'b1;
        if (!dmem_busy) begin
          state_d = StRun;
          wait_d  = '0;
        end else if (wait_q == WaitW'(WAIT_TIMEOUT)) begin
          state_d   = StErr;
          mem_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StErr: begin
        mem_err_d = 1'b1;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_inc && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    if (flush_inc && (flush_q != '1)) flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StRun;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  fwd_sel u_fwd_a (
    .src_i             (id_ex_rs),
    .ex_mem_dst_i      (ex_mem_dst),
    .ex_mem_regwrite_i (ex_mem_regwrite),
    .mem_wb_dst_i      (mem_wb_dst),
    .mem_wb_regwrite_i (mem_wb_regwrite),
    .sel_o             (sel_a)
  );

  fwd_sel u_fwd_b (
    .src_i             (id_ex_rt),
    .ex_mem_dst_i      (ex_mem_dst),
    .ex_mem_regwrite_i (ex_mem_regwrite),
    .mem_wb_dst_i      (mem_wb_dst),
    .mem_wb_regwrite_i (mem_wb_regwrite),
    .sel_o             (sel_b)
  );

  // Reset forces the pipeline registers into bubble and blocks all loads.
  assign pc_en     = reset_n & pc_en_c;
  assign enableIF  = reset_n & en_if_c;
  assign enableID  = reset_n & en_id_c;
  assign resetIF   = ~reset_n | rst_if_c;
  assign resetID   = ~reset_n | rst_id_c;
  assign fwd_a     = reset_n ? sel_a : FWD_REG;
  assign fwd_b     = reset_n ? sel_b : FWD_REG;
  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule
